// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: FSM state encodings
// and the register-address width.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STALL = 2'b01
  } state_e;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance event counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // Holds at all-ones instead of wrapping so long runs stay meaningful.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline,
// with saturating stall/flush event counters.
module hazard_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] RSaddr_IFID_i,
  input  logic [REG_ADDR_W-1:0] RTaddr_IFID_i,
  input  logic                  UseRS_i,
  input  logic                  UseRT_i,
  input  logic                  MemRead_IDEX_i,
  input  logic [REG_ADDR_W-1:0] WriteReg_IDEX_i,
  input  logic                  Branch_taken_MEM_i,
  output logic                  PC_write_o,
  output logic                  IFID_write_o,
  output logic                  IFID_flush_o,
  output logic                  IDEX_flush_o,
  output logic                  EXMEM_flush_o,
  output logic [1:0]            State_o,
  output logic [CNT_W-1:0]      Stall_cnt_o,
  output logic [CNT_W-1:0]      Flush_cnt_o
);

  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_e     r_state;
  logic [3:0] r_rem;
  logic       w_hazard;
  logic       w_stallEvt;
  logic       w_flushEvt;

  // Register $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_hazard = MemRead_IDEX_i && (WriteReg_IDEX_i != '0) &&
                    ((UseRS_i && (WriteReg_IDEX_i == RSaddr_IFID_i)) ||
                     (UseRT_i && (WriteReg_IDEX_i == RTaddr_IFID_i)));

  always_comb begin
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_flush_o  = 1'b0;
    EXMEM_flush_o = 1'b0;
    w_stallEvt    = 1'b0;
    w_flushEvt    = 1'b0;
    if (rst_i) begin
      w_stallEvt = 1'b0;
    end else if (Branch_taken_MEM_i) begin
      IFID_flush_o  = 1'b1;
      IDEX_flush_o  = 1'b1;
      EXMEM_flush_o = 1'b1;
      w_flushEvt    = 1'b1;
    end else if ((r_state == ST_STALL) || ((r_state == ST_IDLE) && w_hazard)) begin
      PC_write_o   = 1'b0;
      IFID_write_o = 1'b0;
      IDEX_flush_o = 1'b1;
      w_stallEvt   = 1'b1;
    end
  end

  // A taken branch abandons any pending stall; the dependent instruction is flushed anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i || Branch_taken_MEM_i) begin
      r_state <= ST_IDLE;
      r_rem   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hazard && (LOAD_STALL_CYCLES > 1)) begin
            r_state <= ST_STALL;
            r_rem   <= STALL_INIT;
          end
        end
        ST_STALL: begin
          if (r_rem == 4'd1) begin
            r_state <= ST_IDLE;
            r_rem   <= 4'd0;
          end else begin
            r_rem <= r_rem - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rem   <= 4'd0;
        end
      endcase
    end
  end

  assign State_o = r_state;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stallEvt),
    .cnt_o (Stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flushEvt),
    .cnt_o (Flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances (N=1/16-bit, N=3/16-bit,
// N=1/2-bit counters) share one stimulus bus.
module tb_hazard_control_unit;

  logic       clock;
  logic       reset;
  logic [4:0] rsAddr;
  logic [4:0] rtAddr;
  logic       useRs;
  logic       useRt;
  logic       memRead;
  logic [4:0] writeReg;
  logic       branchTaken;

  logic        aPcWrite, aIfidWrite, aIfidFlush, aIdexFlush, aExmemFlush;
  logic [1:0]  aState;
  logic [15:0] aStallCnt, aFlushCnt;
  logic        bPcWrite, bIfidWrite, bIfidFlush, bIdexFlush, bExmemFlush;
  logic [1:0]  bState;
  logic [15:0] bStallCnt, bFlushCnt;
  logic        cPcWrite, cIfidWrite, cIfidFlush, cIdexFlush, cExmemFlush;
  logic [1:0]  cState;
  logic [1:0]  cStallCnt, cFlushCnt;

  int compareCount = 0;
  int failCount    = 0;

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dutA (
    .clk_i(clock), .rst_i(reset), .RSaddr_IFID_i(rsAddr), .RTaddr_IFID_i(rtAddr),
    .UseRS_i(useRs), .UseRT_i(useRt), .MemRead_IDEX_i(memRead), .WriteReg_IDEX_i(writeReg),
    .Branch_taken_MEM_i(branchTaken), .PC_write_o(aPcWrite), .IFID_write_o(aIfidWrite),
    .IFID_flush_o(aIfidFlush), .IDEX_flush_o(aIdexFlush), .EXMEM_flush_o(aExmemFlush),
    .State_o(aState), .Stall_cnt_o(aStallCnt), .Flush_cnt_o(aFlushCnt)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dutB (
    .clk_i(clock), .rst_i(reset), .RSaddr_IFID_i(rsAddr), .RTaddr_IFID_i(rtAddr),
    .UseRS_i(useRs), .UseRT_i(useRt), .MemRead_IDEX_i(memRead), .WriteReg_IDEX_i(writeReg),
    .Branch_taken_MEM_i(branchTaken), .PC_write_o(bPcWrite), .IFID_write_o(bIfidWrite),
    .IFID_flush_o(bIfidFlush), .IDEX_flush_o(bIdexFlush), .EXMEM_flush_o(bExmemFlush),
    .State_o(bState), .Stall_cnt_o(bStallCnt), .Flush_cnt_o(bFlushCnt)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) dutC (
    .clk_i(clock), .rst_i(reset), .RSaddr_IFID_i(rsAddr), .RTaddr_IFID_i(rtAddr),
    .UseRS_i(useRs), .UseRT_i(useRt), .MemRead_IDEX_i(memRead), .WriteReg_IDEX_i(writeReg),
    .Branch_taken_MEM_i(branchTaken), .PC_write_o(cPcWrite), .IFID_write_o(cIfidWrite),
    .IFID_flush_o(cIfidFlush), .IDEX_flush_o(cIdexFlush), .EXMEM_flush_o(cExmemFlush),
    .State_o(cState), .Stall_cnt_o(cStallCnt), .Flush_cnt_o(cFlushCnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic [4:0] wr, input logic urs, input logic [4:0] rs,
                               input logic urt, input logic [4:0] rt, input logic br);
    memRead     = mr;
    writeReg    = wr;
    useRs       = urs;
    rsAddr      = rs;
    useRt       = urt;
    rtAddr      = rt;
    branchTaken = br;
    #2;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    step();

    // Reset overrides a live hazard on the control outputs.
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    checkOutput("rst_pcwrite", {31'd0, aPcWrite}, 32'd1);
    checkOutput("rst_idexflush", {31'd0, aIdexFlush}, 32'd0);
    step();
    checkOutput("rst_stallcnt", {16'd0, aStallCnt}, 32'd0);
    checkOutput("rst_flushcnt", {16'd0, aFlushCnt}, 32'd0);
    checkOutput("rst_state", {30'd0, bState}, 32'd0);

    // Load-use on rt.
    reset = 1'b0;
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    checkOutput("rt_pcwrite", {31'd0, aPcWrite}, 32'd0);
    checkOutput("rt_ifidwrite", {31'd0, aIfidWrite}, 32'd0);
    checkOutput("rt_idexflush", {31'd0, aIdexFlush}, 32'd1);
    checkOutput("rt_ifidflush", {31'd0, aIfidFlush}, 32'd0);
    checkOutput("b_state_c1", {30'd0, bState}, 32'd0);
    step();
    clearInputs();
    checkOutput("rt_after_pcwrite", {31'd0, aPcWrite}, 32'd1);
    checkOutput("rt_after_idexflush", {31'd0, aIdexFlush}, 32'd0);
    checkOutput("rt_stallcnt", {16'd0, aStallCnt}, 32'd1);
    checkOutput("b_state_c2", {30'd0, bState}, 32'd1);
    checkOutput("b_pcwrite_c2", {31'd0, bPcWrite}, 32'd0);
    checkOutput("b_idexflush_c2", {31'd0, bIdexFlush}, 32'd1);
    step();
    checkOutput("b_state_c3", {30'd0, bState}, 32'd1);
    checkOutput("b_stallcnt_c3", {16'd0, bStallCnt}, 32'd2);
    step();
    checkOutput("b_state_c4", {30'd0, bState}, 32'd0);
    checkOutput("b_pcwrite_c4", {31'd0, bPcWrite}, 32'd1);
    checkOutput("b_stallcnt_c4", {16'd0, bStallCnt}, 32'd3);

    // Load-use on rs.
    doReset();
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    checkOutput("rs_pcwrite", {31'd0, aPcWrite}, 32'd0);
    step();
    clearInputs();
    checkOutput("rs_stallcnt", {16'd0, aStallCnt}, 32'd1);

    // Register $0 never stalls.
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("r0_pcwrite", {31'd0, aPcWrite}, 32'd1);
    checkOutput("r0_idexflush", {31'd0, aIdexFlush}, 32'd0);
    step();
    clearInputs();
    checkOutput("r0_stallcnt", {16'd0, aStallCnt}, 32'd0);
    checkOutput("r0_b_state", {30'd0, bState}, 32'd0);

    // Matching rt address but rt not read.
    doReset();
    applyStimulus(1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 5'd8, 1'b0);
    checkOutput("nort_pcwrite", {31'd0, aPcWrite}, 32'd1);
    step();
    clearInputs();
    checkOutput("nort_stallcnt", {16'd0, aStallCnt}, 32'd0);

    // Matching address but not a load.
    doReset();
    applyStimulus(1'b0, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    checkOutput("noload_pcwrite", {31'd0, aPcWrite}, 32'd1);
    step();
    clearInputs();

    // Branch in the second cycle of a 3-cycle stall.
    doReset();
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    checkOutput("br_b_pcwrite_c1", {31'd0, bPcWrite}, 32'd0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    checkOutput("br_b_pcwrite", {31'd0, bPcWrite}, 32'd1);
    checkOutput("br_b_ifidwrite", {31'd0, bIfidWrite}, 32'd1);
    checkOutput("br_b_ifidflush", {31'd0, bIfidFlush}, 32'd1);
    checkOutput("br_b_idexflush", {31'd0, bIdexFlush}, 32'd1);
    checkOutput("br_b_exmemflush", {31'd0, bExmemFlush}, 32'd1);
    step();
    clearInputs();
    checkOutput("br_b_state", {30'd0, bState}, 32'd0);
    checkOutput("br_b_flushcnt", {16'd0, bFlushCnt}, 32'd1);
    checkOutput("br_b_stallcnt", {16'd0, bStallCnt}, 32'd1);
    checkOutput("br_b_pcwrite_after", {31'd0, bPcWrite}, 32'd1);

    // Hazard and branch together: branch wins, no stall counted.
    doReset();
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1);
    checkOutput("hb_pcwrite", {31'd0, aPcWrite}, 32'd1);
    checkOutput("hb_ifidflush", {31'd0, aIfidFlush}, 32'd1);
    checkOutput("hb_exmemflush", {31'd0, aExmemFlush}, 32'd1);
    step();
    clearInputs();
    checkOutput("hb_stallcnt", {16'd0, aStallCnt}, 32'd0);
    checkOutput("hb_flushcnt", {16'd0, aFlushCnt}, 32'd1);
    checkOutput("hb_b_state", {30'd0, bState}, 32'd0);

    // Saturation of the 2-bit counter over five stall cycles.
    doReset();
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 3; i++) step();
    checkOutput("sat_c_3", {30'd0, cStallCnt}, 32'd3);
    for (int i = 0; i < 2; i++) step();
    clearInputs();
    checkOutput("sat_c_5", {30'd0, cStallCnt}, 32'd3);
    checkOutput("sat_a_5", {16'd0, aStallCnt}, 32'd5);

    // Reset during a stall aborts it.
    doReset();
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    step();
    clearInputs();
    checkOutput("mid_b_state_pre", {30'd0, bState}, 32'd1);
    reset = 1'b1;
    #2;
    checkOutput("mid_b_pcwrite_rst", {31'd0, bPcWrite}, 32'd1);
    checkOutput("mid_b_idexflush_rst", {31'd0, bIdexFlush}, 32'd0);
    step();
    reset = 1'b0;
    #2;
    checkOutput("mid_b_state", {30'd0, bState}, 32'd0);
    checkOutput("mid_b_stallcnt", {16'd0, bStallCnt}, 32'd0);
    checkOutput("mid_b_flushcnt", {16'd0, bFlushCnt}, 32'd0);
    checkOutput("mid_b_pcwrite", {31'd0, bPcWrite}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
